ans_preamble_stream: RTL and testbench
======================================

Name: ans_preamble_stream

Overview:
- Sequential successor to the combinational L-STF lookup.
- Streams a complete 802.11a/g legacy preamble as packed I/Q samples at one sample per accepted handshake: configurable L-STF repetitions, then an optional L-LTF (32-sample GI2 plus two 64-sample symbols).
- Applies a per-segment obfuscation scaling code, latched at start.
- Sits ahead of the openofdm_tx sample mux and feeds it through a valid/ready interface.

Parameters:
- DATA_W, 16, width of each of I and Q (two's complement); output sample is 2*DATA_W.
- STF_REPS, 10, number of 16-sample L-STF periods emitted; legal 1..10.
- LTF_EN, 1, 1 = append L-LTF after the STF; 0 = STF only.
- NUM_FIELDS, 12, number of 2-bit obfuscation fields; COEFF_W = 2*NUM_FIELDS = 24.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle request to begin a preamble
- coeffs  in  COEFF_W  obfuscation codes; sampled only on accepted start
- busy  out  1  high from accepted start until the last sample is accepted
- out_valid  out  1  sample valid
- out_ready  in  1  downstream accept
- out_symbol  out  2*DATA_W  {I[2*DATA_W-1:DATA_W], Q[DATA_W-1:0]}
- out_last  out  1  high with the final sample of the preamble

Behaviour:
- Reset:
  - State returns to IDLE.
  - busy, out_valid and out_last are 0; out_symbol is 0; latched coeffs are 0.
  - Reset wins over every other input in the same cycle. Reset mid-stream aborts immediately; no further samples are produced.
- States and transitions:
  - IDLE -> STF on start while busy = 0.
  - STF -> LTF_GI after STF_REPS*16 accepted samples, when LTF_EN = 1.
  - STF -> IDLE after STF_REPS*16 accepted samples, when LTF_EN = 0.
  - LTF_GI -> LTF after 32 accepted samples.
  - LTF -> IDLE after 128 accepted samples.
- start while busy is ignored; coeffs are not re-latched.
- Latency:
  - Start accepted in cycle N -> busy = 1 in N+1, out_valid = 1 and first sample on out_symbol in N+1 (registered ROM read).
  - After that, a new sample appears in the cycle after each out_valid & out_ready.
- Handshake:
  - When out_valid = 1 and out_ready = 0, out_symbol and out_last are held stable; counters freeze.
  - out_valid never drops without acceptance.
  - out_ready is ignored while out_valid = 0.
- Sample addressing:
  - STF: addr = sample counter mod 16.
  - LTF_GI: LTF ROM index 32..63.
  - LTF: LTF ROM index 0..63, twice.
- Obfuscation field selection: field f of the latched coeffs is bits [2f+1:2f].
  - STF repetition r (0..STF_REPS-1) uses field r.
  - LTF_GI uses field 10.
  - LTF uses field 11.
- Obfuscation codes, applied identically to I and Q:
  - 00 = unchanged.
  - 01 = unchanged (reserved).
  - 10 = arithmetic shift right by 1.
  - 11 = two's-complement negate, saturating -2^(DATA_W-1) to 2^(DATA_W-1)-1.
- Total sample count: STF_REPS*16 + (LTF_EN ? 160 : 0); 320 at defaults.
- out_last asserts only on the final sample.
- The cycle after the final sample is accepted: busy = 0, out_valid = 0, out_last = 0. start is accepted in that same cycle (back-to-back preambles, no bubble beyond the 1-cycle ROM latency).

Decomposition:
- Shared package ans_preamble_pkg holds:
  - state enum (IDLE, STF, LTF_GI, LTF);
  - obfuscation code constants OBF_NONE, OBF_RSV, OBF_HALF, OBF_NEG;
  - STF_LEN = 16, LTF_GI_LEN = 32, LTF_LEN = 64;
  - field indices FIELD_LTF_GI = 10, FIELD_LTF = 11;
  - ROM constant arrays STF_ROM[16] and LTF_ROM[64], Q1.(DATA_W-1) I/Q pairs.
- Sub-module ans_preamble_rom: registered dual-table lookup (sel, addr) -> packed I/Q with 1-cycle latency.
- FSM, counters, scaling and handshake stay in the top.

Test Plan:
- Default parameters, coeffs = 0, out_ready = 1, start pulse:
  - 320 samples on 320 consecutive cycles;
  - samples 0..159 = STF_ROM[i mod 16];
  - samples 160..191 = LTF_ROM[32..63];
  - samples 192..319 = LTF_ROM[0..63] twice;
  - out_last only on sample 319; busy drops the following cycle.
- coeffs = 24'hAAAAAA: every I and Q equals the unscaled value >>> 1; STF_ROM[0] I and Q both halved arithmetically, sign preserved.
- coeffs = 24'h000003 (field 0 = negate):
  - samples 0..15 are negated;
  - samples 16..159 are unchanged;
  - a ROM value of -2^15 saturates to 16'h7FFF.
- out_ready toggled 1010... plus a 5-cycle low stall at sample 37:
  - out_symbol is held stable during every stall;
  - sequence identical to the first scenario;
  - total still 320 accepts.
- STF_REPS = 2, LTF_EN = 0:
  - exactly 32 samples;
  - out_last on sample 31;
  - a start in the next cycle restarts at STF_ROM[0] with newly latched coeffs.
- Reset asserted at sample 100: next cycle out_valid = 0, busy = 0, out_symbol = 0; start is ignored while busy, and after reset a new start replays from sample 0.

Source files
------------

// File: rtl/ans_preamble_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ans_preamble_pkg                                             |
// | Description : Shared definitions for the legacy-preamble streamer: state   |
// |               encodings, obfuscation codes, segment lengths, field indices |
// |               and the L-STF / L-LTF sample tables.                         |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ans_preamble_pkg;

    // FSM state encodings
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STF    = 2'd1;
    localparam logic [1:0] LTF_GI = 2'd2;
    localparam logic [1:0] LTF    = 2'd3;

    // Obfuscation scaling codes
    localparam logic [1:0] OBF_NONE = 2'b00;
    localparam logic [1:0] OBF_RSV  = 2'b01;
    localparam logic [1:0] OBF_HALF = 2'b10;
    localparam logic [1:0] OBF_NEG  = 2'b11;

    localparam int STF_LEN      = 16;
    localparam int LTF_GI_LEN   = 32;
    localparam int LTF_LEN      = 64;
    localparam int FIELD_LTF_GI = 10;
    localparam int FIELD_LTF    = 11;

    // Native table precision; the ROM rescales to DATA_W.
    localparam int ROM_W = 16;

    function automatic logic [2*ROM_W-1:0] iq(input int ival, input int qval);
        return {ival[ROM_W-1:0], qval[ROM_W-1:0]};
    endfunction

    // L-STF, one 16-sample period. Scaled so that |0.132| hits full scale;
    // the 0.143 entries hard-clip to +32767 and -0.132 lands on -32768.
    localparam logic [2*ROM_W-1:0] STF_ROM [STF_LEN] = '{
        iq( 11419,  11419), iq(-32768,    496), iq( -3227, -19611), iq( 32767,  -3227),
        iq( 22838,      0), iq( 32767,  -3227), iq( -3227, -19611), iq(-32768,    496),
        iq( 11419,  11419), iq(   496, -32768), iq(-19611,  -3227), iq( -3227,  32767),
        iq(     0,  22838), iq( -3227,  32767), iq(-19611,  -3227), iq(   496, -32768)
    };

    // L-LTF, one 64-sample symbol, scaled by 2^17. The guard interval
    // replays entries 32..63.
    localparam logic [2*ROM_W-1:0] LTF_ROM [LTF_LEN] = '{
        iq( 20447,      0), iq(  -655, -15729), iq(  5243, -14549), iq( 12714,  10879),
        iq(  2753,   3670), iq(  7864, -11534), iq(-15073,  -7209), iq( -4981, -13894),
        iq( 12845,  -3408), iq(  6947,    524), iq(   131, -15073), iq(-17957,  -6160),
        iq(  3146,  -7733), iq(  7733,  -1966), iq( -2884,  21103), iq( 15598,   -524),
        iq(  8126,   8126), iq(  4850, -12845), iq( -7471,  -5112), iq(-17170,  -8520),
        iq( 10748, -12059), iq(  9175,  -1835), iq( -7864, -10617), iq( -7340,   2884),
        iq( -4588,  19792), iq(-15991,   2228), iq(-16646,   2753), iq(  9830,   9699),
        iq(  -393,  -7078), iq(-12059,  15073), iq( 12059,  13894), iq(  1573,  12845),
        iq(-20447,      0), iq(  1573, -12845), iq( 12059, -13894), iq(-12059, -15073),
        iq(  -393,   7078), iq(  9830,  -9699), iq(-16646,  -2753), iq(-15991,  -2228),
        iq( -4588, -19792), iq( -7340,  -2884), iq( -7864,  10617), iq(  9175,   1835),
        iq( 10748,  12059), iq(-17170,   8520), iq( -7471,   5112), iq(  4850,  12845),
        iq(  8126,  -8126), iq( 15598,    524), iq( -2884, -21103), iq(  7733,   1966),
        iq(  3146,   7733), iq(-17957,   6160), iq(   131,  15073), iq(  6947,   -524),
        iq( 12845,   3408), iq( -4981,  13894), iq(-15073,   7209), iq(  7864,  11534),
        iq(  2753,  -3670), iq( 12714, -10879), iq(  5243,  14549), iq(  -655,  15729)
    };

endpackage
`default_nettype wire

// File: rtl/ans_preamble_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ans_preamble_rom                                             |
// | Description : Registered dual-table sample lookup, 1-cycle latency.        |
// | Ports       : clock, reset  - clock / synchronous active-high reset        |
// |               en            - load a new sample                            |
// |               sel           - 0 = L-STF table, 1 = L-LTF table             |
// |               addr          - table index (STF uses addr[3:0])             |
// |               data          - {I, Q}, each DATA_W bits                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ans_preamble_rom
    import ans_preamble_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    input  logic                sel,
    input  logic [5:0]          addr,
    output logic [2*DATA_W-1:0] data
);

    logic [2*ROM_W-1:0]  w_entry;
    logic [ROM_W-1:0]    w_i16;
    logic [ROM_W-1:0]    w_q16;
    logic [DATA_W-1:0]   w_i;
    logic [DATA_W-1:0]   w_q;
    logic [2*DATA_W-1:0] r_data;

    assign w_entry = sel ? LTF_ROM[addr] : STF_ROM[addr[3:0]];
    assign w_i16   = w_entry[2*ROM_W-1:ROM_W];
    assign w_q16   = w_entry[ROM_W-1:0];

    // Tables are Q1.15; keep the binary point at the MSB for any DATA_W.
    if (DATA_W == ROM_W) begin : g_native
        assign w_i = w_i16;
        assign w_q = w_q16;
    end else if (DATA_W > ROM_W) begin : g_widen
        assign w_i = {w_i16, {(DATA_W-ROM_W){1'b0}}};
        assign w_q = {w_q16, {(DATA_W-ROM_W){1'b0}}};
    end else begin : g_narrow
        assign w_i = w_i16[ROM_W-1 -: DATA_W];
        assign w_q = w_q16[ROM_W-1 -: DATA_W];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data <= '0;
        end else if (en) begin
            r_data <= {w_i, w_q};
        end
    end

    assign data = r_data;

endmodule
`default_nettype wire

// File: rtl/ans_preamble_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ans_preamble_stream                                          |
// | Description : Streams an 802.11a/g legacy preamble (L-STF reps, optional   |
// |               L-LTF) over valid/ready with per-segment obfuscation.        |
// | Ports       : clock, reset   - clock / synchronous active-high reset       |
// |               start, coeffs  - begin preamble; codes latched on accept     |
// |               busy           - preamble in progress                        |
// |               out_valid/out_ready/out_symbol/out_last - sample stream      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ans_preamble_stream
    import ans_preamble_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int STF_REPS   = 10,
    parameter int LTF_EN     = 1,
    parameter int NUM_FIELDS = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [2*NUM_FIELDS-1:0] coeffs,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_W-1:0]     out_symbol,
    output logic                    out_last
);

    localparam logic [7:0] c_stf_last  = 8'(STF_REPS*STF_LEN - 1);
    localparam logic [7:0] c_gi_last   = 8'(LTF_GI_LEN - 1);
    localparam logic [7:0] c_ltf_last  = 8'(2*LTF_LEN - 1);
    localparam logic [4:0] c_field_gi  = 5'(FIELD_LTF_GI);
    localparam logic [4:0] c_field_ltf = 5'(FIELD_LTF);

    // State/counter describe the sample currently presented on out_symbol.
    logic [1:0]              r_state, w_nstate;
    logic [7:0]              r_cnt, w_ncnt;
    logic                    r_valid, w_nvalid;
    logic                    r_last, w_nlast;
    logic [1:0]              r_code, w_ncode;
    logic [2*NUM_FIELDS-1:0] r_coeffs, w_coeffs;
    logic                    w_load, w_adv, w_sel;
    logic [5:0]              w_addr;
    logic [4:0]              w_field;
    logic [2*DATA_W-1:0]     w_rom_data;

    assign w_adv    = r_valid & out_ready;
    // The first sample's code must come from coeffs as it is being latched.
    assign w_coeffs = (r_state == IDLE) ? coeffs : r_coeffs;

    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_nvalid = r_valid;
        w_load   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nstate = STF;
                    w_ncnt   = '0;
                    w_nvalid = 1'b1;
                    w_load   = 1'b1;
                end
            end
            STF: begin
                if (w_adv) begin
                    if (r_cnt != c_stf_last) begin
                        w_ncnt = r_cnt + 8'd1;
                        w_load = 1'b1;
                    end else if (LTF_EN != 0) begin
                        w_nstate = LTF_GI;
                        w_ncnt   = '0;
                        w_load   = 1'b1;
                    end else begin
                        w_nstate = IDLE;
                        w_ncnt   = '0;
                        w_nvalid = 1'b0;
                    end
                end
            end
            LTF_GI: begin
                if (w_adv) begin
                    if (r_cnt != c_gi_last) begin
                        w_ncnt = r_cnt + 8'd1;
                    end else begin
                        w_nstate = LTF;
                        w_ncnt   = '0;
                    end
                    w_load = 1'b1;
                end
            end
            LTF: begin
                if (w_adv) begin
                    if (r_cnt != c_ltf_last) begin
                        w_ncnt = r_cnt + 8'd1;
                        w_load = 1'b1;
                    end else begin
                        w_nstate = IDLE;
                        w_ncnt   = '0;
                        w_nvalid = 1'b0;
                    end
                end
            end
            default: begin
                w_nstate = IDLE;
                w_ncnt   = '0;
                w_nvalid = 1'b0;
            end
        endcase
    end

    // Fetch address, obfuscation field and last flag for the sample being loaded.
    always_comb begin
        w_sel   = 1'b0;
        w_addr  = {2'b00, w_ncnt[3:0]};
        w_field = {1'b0, w_ncnt[7:4]};
        w_nlast = 1'b0;
        case (w_nstate)
            STF: begin
                w_nlast = (LTF_EN == 0) && (w_ncnt == c_stf_last);
            end
            LTF_GI: begin
                w_sel   = 1'b1;
                w_addr  = {1'b1, w_ncnt[4:0]};
                w_field = c_field_gi;
            end
            LTF: begin
                w_sel   = 1'b1;
                w_addr  = w_ncnt[5:0];
                w_field = c_field_ltf;
                w_nlast = (w_ncnt == c_ltf_last);
            end
            default: ;
        endcase
        w_ncode = w_coeffs[2*w_field +: 2];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_code   <= OBF_NONE;
            r_coeffs <= '0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_valid <= w_nvalid;
            if ((r_state == IDLE) && start) begin
                r_coeffs <= coeffs;
            end
            if (w_load) begin
                r_last <= w_nlast;
                r_code <= w_ncode;
            end else if (!w_nvalid) begin
                r_last <= 1'b0;
            end
        end
    end

    ans_preamble_rom #(
        .DATA_W (DATA_W)
    ) u_rom (
        .clock (clock),
        .reset (reset),
        .en    (w_load),
        .sel   (w_sel),
        .addr  (w_addr),
        .data  (w_rom_data)
    );

    function automatic logic [DATA_W-1:0] obf(input logic [DATA_W-1:0] x, input logic [1:0] code);
        logic [DATA_W-1:0] y;
        y = x;
        case (code)
            OBF_NONE, OBF_RSV: y = x;
            OBF_HALF:          y = {x[DATA_W-1], x[DATA_W-1:1]};
            // The most negative value has no positive twin; clamp it.
            OBF_NEG:           y = (x == {1'b1, {(DATA_W-1){1'b0}}}) ? {1'b0, {(DATA_W-1){1'b1}}}
                                                                    : (~x + 1'b1);
        endcase
        return y;
    endfunction

    assign out_symbol = {obf(w_rom_data[2*DATA_W-1:DATA_W], r_code),
                         obf(w_rom_data[DATA_W-1:0], r_code)};
    assign out_valid  = r_valid;
    assign busy       = r_valid;
    assign out_last   = r_last;

endmodule
`default_nettype wire

// File: tb/tb_ans_preamble_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ans_preamble_stream                                       |
// | Description : Scoreboard bench for ans_preamble_stream (default build and  |
// |               a 2-rep STF-only build).                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ans_preamble_stream;
    import ans_preamble_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Default build
    logic        reset, start, out_ready;
    logic [23:0] coeffs;
    logic        busy, out_valid, out_last;
    logic [31:0] out_symbol;
    // STF_REPS = 2, LTF_EN = 0 build
    logic        reset2, start2, out_ready2;
    logic [23:0] coeffs2;
    logic        busy2, out_valid2, out_last2;
    logic [31:0] out_symbol2;

    ans_preamble_stream dut (
        .clock(clock), .reset(reset), .start(start), .coeffs(coeffs), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_symbol(out_symbol), .out_last(out_last)
    );

    ans_preamble_stream #(.STF_REPS(2), .LTF_EN(0)) dut2 (
        .clock(clock), .reset(reset2), .start(start2), .coeffs(coeffs2), .busy(busy2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_symbol(out_symbol2), .out_last(out_last2)
    );

    typedef struct packed {
        logic [31:0] sym;
        logic        last;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int total = 0;
    int bad   = 0;
    int acc1  = 0;
    int acc2  = 0;
    logic        hold1 = 1'b0;
    logic [31:0] hold_sym = '0;
    logic        hold_last = 1'b0;

    function automatic logic [15:0] sc(input logic [15:0] x, input logic [1:0] c);
        if (c == 2'b10) return {x[15], x[15:1]};
        if (c == 2'b11) return (x == 16'h8000) ? 16'h7FFF : 16'(0 - int'($signed(x)));
        return x;
    endfunction

    function automatic logic [31:0] exp_sym(input int k, input int reps, input logic [23:0] c);
        logic [31:0] raw;
        logic [1:0]  code;
        if (k < reps*16) begin
            raw  = STF_ROM[k % 16];
            code = c[2*(k/16) +: 2];
        end else if (k < reps*16 + 32) begin
            raw  = LTF_ROM[32 + k - reps*16];
            code = c[21:20];
        end else begin
            raw  = LTF_ROM[(k - reps*16 - 32) % 64];
            code = c[23:22];
        end
        return {sc(raw[31:16], code), sc(raw[15:0], code)};
    endfunction

    task automatic push_exp(input int which, input int reps, input bit ltf, input logic [23:0] c);
        exp_t e;
        int n;
        n = reps*16 + (ltf ? 160 : 0);
        for (int k = 0; k < n; k++) begin
            e.sym  = exp_sym(k, reps, c);
            e.last = (k == n-1);
            if (which == 1) q1.push_back(e);
            else            q2.push_back(e);
        end
    endtask

    // One clock: observe at the falling edge, return 1 time unit after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        if (hold1 && !reset) begin
            total++;
            if ({out_valid, out_last, out_symbol} !== {1'b1, hold_last, hold_sym}) begin
                bad++;
                $display("FAIL stall_hold: got valid=%b last=%b sym=%h, want valid=1 last=%b sym=%h",
                         out_valid, out_last, out_symbol, hold_last, hold_sym);
            end
        end
        hold1     = out_valid && !out_ready && !reset;
        hold_sym  = out_symbol;
        hold_last = out_last;
        if (out_valid && out_ready && !reset) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL dut_extra_sample: got sym=%h, want no sample", out_symbol);
            end else begin
                e = q1.pop_front();
                if ({out_symbol, out_last} !== {e.sym, e.last}) begin
                    bad++;
                    $display("FAIL dut_sample %0d: got sym=%h last=%b, want sym=%h last=%b",
                             acc1, out_symbol, out_last, e.sym, e.last);
                end
            end
            acc1++;
        end
        if (out_valid2 && out_ready2 && !reset2) begin
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL dut2_extra_sample: got sym=%h, want no sample", out_symbol2);
            end else begin
                e = q2.pop_front();
                if ({out_symbol2, out_last2} !== {e.sym, e.last}) begin
                    bad++;
                    $display("FAIL dut2_sample %0d: got sym=%h last=%b, want sym=%h last=%b",
                             acc2, out_symbol2, out_last2, e.sym, e.last);
                end
            end
            acc2++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_start1(input logic [23:0] c, input logic [31:0] first);
        start  = 1'b1;
        coeffs = c;
        push_exp(1, 10, 1'b1, c);
        tick();
        start  = 1'b0;
        coeffs = 24'($urandom);
        total++;
        if ({busy, out_valid, out_symbol} !== {2'b11, first}) begin
            bad++;
            $display("FAIL start_latency: got busy=%b valid=%b sym=%h, want busy=1 valid=1 sym=%h",
                     busy, out_valid, out_symbol, first);
        end
    endtask

    task automatic wait_idle1(input int budget, output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        total++;
        if ({busy, out_valid, out_last} !== 3'b000) begin
            bad++;
            $display("FAIL idle_after_last: got busy=%b valid=%b last=%b, want 000", busy, out_valid, out_last);
        end
        total++;
        if (q1.size() != 0) begin
            bad++;
            $display("FAIL samples_missing: got %0d left over, want 0", q1.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; reset2 = 1'b1; start = 1'b0; start2 = 1'b0;
        out_ready = 1'b1; out_ready2 = 1'b1; coeffs = '0; coeffs2 = '0;
        repeat (3) tick();
        start = 1'b1;   // reset must win over start
        tick();
        start = 1'b0;
        total++;
        if ({busy, out_valid, out_last, out_symbol} !== 35'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b valid=%b last=%b sym=%h, want all 0",
                     busy, out_valid, out_last, out_symbol);
        end
        total++;
        if ({busy2, out_valid2, out_last2, out_symbol2} !== 35'd0) begin
            bad++;
            $display("FAIL reset_state2: got busy=%b valid=%b sym=%h, want all 0", busy2, out_valid2, out_symbol2);
        end
        reset = 1'b0; reset2 = 1'b0;
        tick();
    endtask

    task automatic test_plain();
        int base, cyc;
        base = acc1;
        out_ready = 1'b1;
        do_start1(24'h000000, 32'h2C9B2C9B);
        wait_idle1(400, cyc);
        total++;
        if (cyc != 320 || acc1 - base != 320) begin
            bad++;
            $display("FAIL plain_count: got cycles=%0d accepts=%0d, want 320 and 320", cyc, acc1 - base);
        end
    endtask

    task automatic test_half();
        int cyc;
        do_start1(24'hAAAAAA, 32'h164D164D);
        tick();
        total++;
        if (out_symbol !== 32'hC00000F8) begin
            bad++;
            $display("FAIL half_sample1: got %h, want c00000f8", out_symbol);
        end
        wait_idle1(400, cyc);
    endtask

    task automatic test_negate();
        int cyc;
        do_start1(24'h000003, 32'hD365D365);
        tick();
        total++;
        if (out_symbol !== 32'h7FFFFE10) begin
            bad++;
            $display("FAIL negate_saturate: got %h, want 7fff fe10", out_symbol);
        end
        wait_idle1(400, cyc);
    endtask

    task automatic test_stall();
        int base, cyc, low;
        bit stalled;
        base = acc1; cyc = 0; low = 0; stalled = 1'b0;
        do_start1(24'h000000, 32'h2C9B2C9B);
        while (busy === 1'b1 && cyc < 2000) begin
            if (!stalled && acc1 - base == 37) begin
                stalled = 1'b1;
                low = 5;
            end
            if (low > 0) begin
                out_ready = 1'b0;
                low--;
            end else begin
                out_ready = (cyc % 2 == 0);
            end
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        wait_idle1(10, cyc);
        total++;
        if (acc1 - base != 320 || !stalled) begin
            bad++;
            $display("FAIL stall_count: got accepts=%0d stalled=%b, want 320 and 1", acc1 - base, stalled);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, base;
        base = acc2;
        start2 = 1'b1; coeffs2 = 24'hFFFFF0;   // fields 0,1 unchanged
        push_exp(2, 2, 1'b0, 24'hFFFFF0);
        tick();
        start2 = 1'b0; coeffs2 = 24'h000003;
        cyc = 0;
        while (out_last2 !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        total++;
        if (cyc != 31) begin
            bad++;
            $display("FAIL b2b_last_pos: got last at sample %0d, want 31", cyc);
        end
        tick();
        total++;
        if ({busy2, out_valid2, out_last2} !== 3'b000) begin
            bad++;
            $display("FAIL b2b_gap: got busy=%b valid=%b last=%b, want 000", busy2, out_valid2, out_last2);
        end
        start2 = 1'b1; coeffs2 = 24'h000002;
        push_exp(2, 2, 1'b0, 24'h000002);
        tick();
        start2 = 1'b0; coeffs2 = 24'hFFFFFF;
        total++;
        if ({out_valid2, out_symbol2} !== {1'b1, 32'h164D164D}) begin
            bad++;
            $display("FAIL b2b_restart: got valid=%b sym=%h, want valid=1 sym=164d164d", out_valid2, out_symbol2);
        end
        cyc = 0;
        while (busy2 === 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        total++;
        if (cyc != 32 || acc2 - base != 64 || q2.size() != 0 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_count: got cycles=%0d accepts=%0d left=%0d busy=%b, want 32 64 0 0",
                     cyc, acc2 - base, q2.size(), busy2);
        end
    endtask

    task automatic test_abort();
        int base, cyc;
        bit pulsed;
        base = acc1; cyc = 0; pulsed = 1'b0;
        out_ready = 1'b1;
        do_start1(24'h000000, 32'h2C9B2C9B);
        while (acc1 - base < 100 && cyc < 500) begin
            if (!pulsed && acc1 - base == 50) begin
                start = 1'b1; coeffs = 24'hFFFFFF;   // ignored while busy
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        total++;
        if (acc1 - base != 100) begin
            bad++;
            $display("FAIL abort_reach: got accepts=%0d, want 100", acc1 - base);
        end
        reset = 1'b1;
        q1.delete();
        tick();
        reset = 1'b0;
        total++;
        if ({busy, out_valid, out_last, out_symbol} !== 35'd0) begin
            bad++;
            $display("FAIL abort_state: got busy=%b valid=%b last=%b sym=%h, want all 0",
                     busy, out_valid, out_last, out_symbol);
        end
        repeat (3) tick();
        total++;
        if ({busy, out_valid} !== 2'b00) begin
            bad++;
            $display("FAIL abort_quiet: got busy=%b valid=%b, want 00", busy, out_valid);
        end
        do_start1(24'h000000, 32'h2C9B2C9B);
        wait_idle1(400, cyc);
    endtask

    initial begin
        test_reset();
        test_plain();
        test_half();
        test_negate();
        test_stall();
        test_back_to_back();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
